// File: rtl/walk_register.sv
// ============================================================================
// Module      : walk_register
// Description : Pedestrian walk-request latch. Captures a synchronized
//               push-button request and holds it as WR until the controller
//               FSM clears it with WR_Reset. Also keeps request bookkeeping:
//               press count, pending age and set/served pulses.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   CNT_W     width of the saturating press counter (WR_Count)
//   AGE_W     width of the saturating pending-age counter (WR_Age)
// Ports:
//   clk       system clock, all state updates on its rising edge
//   reset     synchronous, active-high; clears all state
//   WR_Sync   walk button, already synchronized to clk
//   WR_Reset  clear request from the controller FSM (walk served)
//   WR        walk request pending (registered)
//   WR_Count  accepted set events since the last clear (saturating)
//   WR_Age    cycles WR has been continuously pending (saturating)
//   WR_Rise   one-cycle pulse after WR goes 0 -> 1
//   WR_Served one-cycle pulse after a pending request is cleared
// Configuration:
//   WALK_EDGE_DETECT_EN  defined   : a set event needs a 0 -> 1 change of
//                                    WR_Sync between consecutive samples
//                        undefined : every cycle with WR_Sync = 1 is a set
// ============================================================================
`default_nettype none

module walk_register #(
  parameter int CNT_W = 4,
  parameter int AGE_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             WR_Sync,
  input  logic             WR_Reset,
  output logic             WR,
  output logic [CNT_W-1:0] WR_Count,
  output logic [AGE_W-1:0] WR_Age,
  output logic             WR_Rise,
  output logic             WR_Served
);

  localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [AGE_W-1:0] c_AGE_MAX = {AGE_W{1'b1}};
  localparam logic [AGE_W-1:0] c_AGE_ONE = {{(AGE_W-1){1'b0}}, 1'b1};

  logic             wr_q,     wr_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [AGE_W-1:0] age_q,    age_d;
  logic             rise_q,   rise_d;
  logic             served_q, served_d;

  logic             w_set;
  logic             w_clr;

  assign w_clr = WR_Reset;

`ifdef WALK_EDGE_DETECT_EN
  // Previous button sample; cleared by reset so a button already held on
  // the first post-reset cycle is seen as a fresh press.
  logic sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= 1'b0;
    end else begin
      sync_q <= WR_Sync;
    end
  end

  assign w_set = WR_Sync & ~sync_q;
`else
  assign w_set = WR_Sync;
`endif

  // Next-state: set wins over clear so a press arriving in the same cycle
  // as the serve is kept as a new request.
  always_comb begin
    wr_d     = wr_q;
    cnt_d    = cnt_q;
    age_d    = age_q;
    rise_d   = 1'b0;
    served_d = 1'b0;

    if (w_set) begin
      wr_d = 1'b1;
      if (w_clr || !wr_q) begin
        // Fresh request (either from idle or restarted by a coincident serve)
        cnt_d = c_CNT_ONE;
        age_d = '0;
      end else begin
        cnt_d = (cnt_q == c_CNT_MAX) ? cnt_q : cnt_q + c_CNT_ONE;
        age_d = (age_q == c_AGE_MAX) ? age_q : age_q + c_AGE_ONE;
      end
    end else if (w_clr) begin
      wr_d  = 1'b0;
      cnt_d = '0;
      age_d = '0;
    end else if (wr_q) begin
      // Request still pending: only the age advances
      age_d = (age_q == c_AGE_MAX) ? age_q : age_q + c_AGE_ONE;
    end else begin
      age_d = '0;
    end

    rise_d   = wr_d & ~wr_q;
    // A clear only counts as a serve when something was pending
    served_d = w_clr & wr_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q     <= 1'b0;
      cnt_q    <= '0;
      age_q    <= '0;
      rise_q   <= 1'b0;
      served_q <= 1'b0;
    end else begin
      wr_q     <= wr_d;
      cnt_q    <= cnt_d;
      age_q    <= age_d;
      rise_q   <= rise_d;
      served_q <= served_d;
    end
  end

  assign WR        = wr_q;
  assign WR_Count  = cnt_q;
  assign WR_Age    = age_q;
  assign WR_Rise   = rise_q;
  assign WR_Served = served_q;

endmodule

`default_nettype wire

// File: tb/tb_walk_register.sv
// ============================================================================
// Module      : tb_walk_register
// Description : Scoreboard bench for walk_register with narrow counters
//               (CNT_W = 2, AGE_W = 3) so both saturation limits are reached.
//               Expected values are hand-computed per cycle; rows that differ
//               between level and edge mode are selected with
//               WALK_EDGE_DETECT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_walk_register;

  localparam int CNT_W = 2;
  localparam int AGE_W = 3;

  logic             clk;
  logic             reset;
  logic             WR_Sync;
  logic             WR_Reset;
  logic             WR;
  logic [CNT_W-1:0] WR_Count;
  logic [AGE_W-1:0] WR_Age;
  logic             WR_Rise;
  logic             WR_Served;

  walk_register #(
    .CNT_W (CNT_W),
    .AGE_W (AGE_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .WR_Sync   (WR_Sync),
    .WR_Reset  (WR_Reset),
    .WR        (WR),
    .WR_Count  (WR_Count),
    .WR_Age    (WR_Age),
    .WR_Rise   (WR_Rise),
    .WR_Served (WR_Served)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic             wr;
    logic [CNT_W-1:0] cnt;
    logic [AGE_W-1:0] age;
    logic             rise;
    logic             served;
  } exp_t;

  exp_t exp_q[$];
  int   row_id_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   row      = 0;

  task automatic check(input string name, input int r, input int act, input int expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL row %0d %s: got %0d expected %0d", r, name, act, expv);
    end
  endtask

  // Monitor: outputs are registered and valid every cycle, so one expected
  // entry is retired just after each rising edge that follows a stimulus.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      int   r;
      e = exp_q.pop_front();
      r = row_id_q.pop_front();
      check("WR",        r, int'(WR),        int'(e.wr));
      check("WR_Count",  r, int'(WR_Count),  int'(e.cnt));
      check("WR_Age",    r, int'(WR_Age),    int'(e.age));
      check("WR_Rise",   r, int'(WR_Rise),   int'(e.rise));
      check("WR_Served", r, int'(WR_Served), int'(e.served));
    end
  end

  // Drive one cycle of inputs and queue the outputs expected after the edge.
  task automatic step(input logic rst, input logic s, input logic c,
                      input logic ewr, input int ecnt, input int eage,
                      input logic erise, input logic esrv);
    exp_t e;
    @(negedge clk);
    reset    = rst;
    WR_Sync  = s;
    WR_Reset = c;
    e.wr     = ewr;
    e.cnt    = ecnt[CNT_W-1:0];
    e.age    = eage[AGE_W-1:0];
    e.rise   = erise;
    e.served = esrv;
    exp_q.push_back(e);
    row_id_q.push_back(row);
    row++;
  endtask

  initial begin
    reset    = 1'b1;
    WR_Sync  = 1'b0;
    WR_Reset = 1'b0;

    //     rst  sync clr   WR  cnt age rise srv
    step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);   // reset
    step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);   // reset held
    step(1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0);   // clear while idle: no pulse
    step(1'b0, 1'b1, 1'b1, 1'b1, 1, 0, 1'b1, 1'b0);   // set+clr from idle
    step(1'b0, 1'b0, 1'b0, 1'b1, 1, 1, 1'b0, 1'b0);   // hold, age 1
    step(1'b0, 1'b1, 1'b0, 1'b1, 2, 2, 1'b0, 1'b0);   // second press
`ifdef WALK_EDGE_DETECT_EN
    step(1'b0, 1'b1, 1'b0, 1'b1, 2, 3, 1'b0, 1'b0);   // held: counted once
    step(1'b0, 1'b1, 1'b0, 1'b1, 2, 4, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 2, 5, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 2, 6, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 2, 7, 1'b0, 1'b0);   // age at max
    step(1'b0, 1'b0, 1'b0, 1'b1, 2, 7, 1'b0, 1'b0);   // age saturated
`else
    step(1'b0, 1'b1, 1'b0, 1'b1, 3, 3, 1'b0, 1'b0);   // count reaches max
    step(1'b0, 1'b1, 1'b0, 1'b1, 3, 4, 1'b0, 1'b0);   // count saturated
    step(1'b0, 1'b1, 1'b0, 1'b1, 3, 5, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 3, 6, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 3, 7, 1'b0, 1'b0);   // age at max
    step(1'b0, 1'b0, 1'b0, 1'b1, 3, 7, 1'b0, 1'b0);   // age saturated
`endif
    step(1'b0, 1'b1, 1'b1, 1'b1, 1, 0, 1'b0, 1'b1);   // serve + new request
    step(1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b1);   // plain serve
    step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);   // served pulse ends
    step(1'b0, 1'b1, 1'b0, 1'b1, 1, 0, 1'b1, 1'b0);   // new press
`ifdef WALK_EDGE_DETECT_EN
    step(1'b0, 1'b1, 1'b0, 1'b1, 1, 1, 1'b0, 1'b0);
`else
    step(1'b0, 1'b1, 1'b0, 1'b1, 2, 1, 1'b0, 1'b0);
`endif
    step(1'b1, 1'b1, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0);   // reset dominates, no serve
    step(1'b0, 1'b1, 1'b0, 1'b1, 1, 0, 1'b1, 1'b0);   // held button after reset
    step(1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b1);   // serve
    step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1, 0, 1'b1, 1'b0);   // press
`ifdef WALK_EDGE_DETECT_EN
    step(1'b0, 1'b1, 1'b1, 1'b0, 0, 0, 1'b0, 1'b1);   // held button is not a set
    step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
`else
    step(1'b0, 1'b1, 1'b1, 1'b1, 1, 0, 1'b0, 1'b1);   // held button re-requests
    step(1'b0, 1'b0, 1'b0, 1'b1, 1, 1, 1'b0, 1'b0);
`endif

    @(negedge clk);
    WR_Sync  = 1'b0;
    WR_Reset = 1'b0;

    // Bounded drain of the scoreboard
    begin
      int waited;
      waited = 0;
      while (exp_q.size() > 0 && waited < 20) begin
        @(negedge clk);
        waited++;
      end
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending entries expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
